// File: rtl/cc_receive_pkg.sv
// Shared definitions for the CC serial link: receiver state encoding and
// default framing parameters common to transmitter and receiver.
package cc_receive_pkg;

  localparam int CC_SUBFRAME     = 2048;
  localparam int CC_BIT_PERIOD   = 51;
  localparam int CC_IDLE_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } rx_state_t;

endpackage

// File: rtl/cc_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so no false start bit appears after reset.
module cc_sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cc_receive.sv
// CC serial receiver: 8N1 bytes sampled mid-bit, written sequentially into a
// subframe RAM with framing-error and idle-timeout resynchronisation.
module cc_receive
  import cc_receive_pkg::*;
#(
  parameter int SUBFRAME     = CC_SUBFRAME,
  parameter int BIT_PERIOD   = CC_BIT_PERIOD,
  parameter int IDLE_TIMEOUT = CC_IDLE_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx,
  output logic [11:0] wraddress,
  output logic [7:0]  wrdata,
  output logic        wren,
  output logic        DONE,
  output logic        frame_err,
  output logic        sync_lost
);

  localparam int CNT_W = $clog2(BIT_PERIOD + 1);
  localparam int IDL_W = $clog2(IDLE_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
  localparam logic [IDL_W-1:0] IDLE_MAX  = IDL_W'(IDLE_TIMEOUT);
  localparam logic [IDL_W-1:0] IDLE_LAST = IDL_W'(IDLE_TIMEOUT - 1);
  localparam logic [12:0]      LAST_ADDR = 13'(SUBFRAME - 1);

  logic             rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic [12:0]      byte_cnt;
  logic [IDL_W-1:0] idle_cnt;

  cc_sync2 u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      byte_cnt  <= '0;
      idle_cnt  <= '0;
      wraddress <= '0;
      wrdata    <= '0;
      wren      <= 1'b0;
      DONE      <= 1'b0;
      frame_err <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      wren      <= 1'b0;
      DONE      <= 1'b0;
      frame_err <= 1'b0;
      sync_lost <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            bit_cnt  <= '0;
            idle_cnt <= '0;
            state    <= S_START;
          end else if (idle_cnt < IDLE_MAX) begin
            idle_cnt <= idle_cnt + 1'b1;
            // A stalled partial subframe is abandoned exactly once per idle period
            if (idle_cnt == IDLE_LAST && byte_cnt != '0) begin
              sync_lost <= 1'b1;
              byte_cnt  <= '0;
            end
          end
        end
        S_START: begin
          if (bit_cnt == HALF_LAST) begin
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              bit_cnt <= '0;
              bit_idx <= '0;
              state   <= S_DATA;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            shift[bit_idx] <= rx_s;
            bit_cnt        <= '0;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (rx_s) begin
              wren      <= 1'b1;
              wrdata    <= shift;
              wraddress <= byte_cnt[11:0];
              if (byte_cnt == LAST_ADDR) begin
                DONE     <= 1'b1;
                byte_cnt <= '0;
              end else begin
                byte_cnt <= byte_cnt + 1'b1;
              end
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_WAIT_HIGH;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_receive.sv
// Directed plus randomized bench for cc_receive with a byte-level reference
// model of subframe addressing, DONE, framing errors and idle timeout.
module tb_cc_receive;

  localparam int SUBFRAME     = 4;
  localparam int BIT_PERIOD   = 51;
  localparam int IDLE_TIMEOUT = 300;
  localparam int MAXW         = 128;

  logic        clock;
  logic        reset;
  logic        rx;
  logic [11:0] wraddress;
  logic [7:0]  wrdata;
  logic        wren;
  logic        DONE;
  logic        frame_err;
  logic        sync_lost;

  cc_receive #(
    .SUBFRAME     (SUBFRAME),
    .BIT_PERIOD   (BIT_PERIOD),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .wraddress (wraddress),
    .wrdata    (wrdata),
    .wren      (wren),
    .DONE      (DONE),
    .frame_err (frame_err),
    .sync_lost (sync_lost)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Event log filled by the monitor, read by the stimulus process.
  logic [11:0] wr_addr [MAXW];
  logic [7:0]  wr_data [MAXW];
  logic        wr_done [MAXW];
  int n_wr = 0, n_done = 0, n_fe = 0, n_sl = 0, n_wide = 0;
  logic p_wren = 1'b0, p_done = 1'b0, p_fe = 1'b0, p_sl = 1'b0;

  always @(negedge clock) begin
    if (wren && n_wr < MAXW) begin
      wr_addr[n_wr] <= wraddress;
      wr_data[n_wr] <= wrdata;
      wr_done[n_wr] <= DONE;
    end
    if (wren) n_wr <= n_wr + 1;
    if (DONE) n_done <= n_done + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (sync_lost) n_sl <= n_sl + 1;
    if ((wren && p_wren) || (DONE && p_done) || (frame_err && p_fe) || (sync_lost && p_sl))
      n_wide <= n_wide + 1;
    p_wren <= wren;
    p_done <= DONE;
    p_fe   <= frame_err;
    p_sl   <= sync_lost;
  end

  int checks = 0;
  int failures = 0;
  int model_addr = 0;
  int model_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_PERIOD) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok, input int gap);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop_ok);
    rx = 1'b1;
    repeat (gap) @(negedge clock);
  endtask

  // Send one byte and compare the DUT against the model's expectation.
  task automatic expect_byte(input string tag, input logic [7:0] d, input logic stop_ok);
    int w0, fe0, idx;
    logic exp_done;
    w0  = n_wr;
    fe0 = n_fe;
    send_byte(d, stop_ok, 20 + int'($urandom_range(0, 20)));
    if (stop_ok) begin
      exp_done = (model_addr == SUBFRAME - 1);
      check({tag, "_wren_count"}, n_wr - w0, 1);
      idx = (w0 < MAXW) ? w0 : MAXW - 1;
      check({tag, "_addr"}, wr_addr[idx], model_addr);
      check({tag, "_data"}, wr_data[idx], d);
      check({tag, "_done"}, wr_done[idx], exp_done);
      check({tag, "_no_ferr"}, n_fe - fe0, 0);
      if (exp_done) model_done++;
      model_addr = (model_addr + 1) % SUBFRAME;
    end else begin
      check({tag, "_ferr_count"}, n_fe - fe0, 1);
      check({tag, "_no_wren"}, n_wr - w0, 0);
    end
  endtask

  task automatic expect_idle(input string tag);
    int sl0;
    sl0 = n_sl;
    rx = 1'b1;
    repeat (IDLE_TIMEOUT + 40) @(negedge clock);
    check({tag, "_sync_lost"}, n_sl - sl0, (model_addr != 0) ? 1 : 0);
    model_addr = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_wraddress"}, wraddress, 0);
    check({tag, "_wrdata"}, wrdata, 0);
    check({tag, "_pulses"}, {wren, DONE, frame_err, sync_lost}, 0);
  endtask

  initial begin
    int w0, fe0, sl0;
    logic [7:0] rb;
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;
    repeat (10) @(negedge clock);

    expect_byte("a5", 8'hA5, 1'b1);

    w0 = n_wr; fe0 = n_fe; sl0 = n_sl;
    rx = 1'b0;
    repeat (10) @(negedge clock);
    rx = 1'b1;
    repeat (60) @(negedge clock);
    check("glitch_no_wren", n_wr - w0, 0);
    check("glitch_no_err", (n_fe - fe0) + (n_sl - sl0), 0);

    expect_byte("3c_bad", 8'h3C, 1'b0);
    expect_byte("11_after_ferr", 8'h11, 1'b1);
    expect_idle("timeout_partial");

    for (int i = 1; i <= 5; i++) expect_byte("seq", 8'(i), 1'b1);
    expect_idle("timeout_one");
    expect_idle("timeout_empty");

    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom);
      expect_byte("rand", rb, ($urandom_range(0, 3) != 0));
    end

    expect_byte("two_a", 8'h5A, 1'b1);
    expect_byte("two_b", 8'hC3, 1'b1);
    expect_idle("timeout_two");
    expect_byte("after_timeout", 8'h96, 1'b1);

    // Reset in the middle of data bit 4 of a byte.
    w0 = n_wr;
    rb = 8'hFF;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rb[i]);
    rx = rb[4];
    repeat (20) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check_outputs_zero("reset_mid");
    reset = 1'b0;
    rx = 1'b1;
    repeat (30) @(negedge clock);
    check("reset_mid_no_wren", n_wr - w0, 0);
    model_addr = 0;
    expect_byte("7e_after_reset", 8'h7E, 1'b1);

    check("done_total", n_done, model_done);
    check("pulse_width", n_wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
